// File: rtl/sevenseg_scan_n.sv
// Multiplexed seven-segment scanner with double-buffered digits, anti-ghost guard and PWM dimming.
// Optional leading-zero blanking is compiled in when SEVENSEG_LZB_EN is defined.
module sevenseg_scan_n #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 12500,
    parameter int PWM_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dps,
    input  logic                    load,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    logic [SLOT_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]        idx;
    logic [PWM_BITS-1:0]     pwm_cnt;
    logic                    pending;
    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   shadow_dps;

    logic                    slot_last;
    logic                    frame_last;
    logic                    lit;
    logic [3:0]              cur_nibble;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        case (nibble)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    assign slot_last  = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
    assign frame_last = slot_last && (idx == IDX_W'(NUM_DIGITS - 1));
    assign cur_nibble = shadow_digits[4*idx +: 4];
    assign lit        = (&brightness) || (pwm_cnt < brightness);

    // Slot 0 keeps every anode off so the segment change settles before the digit lights.
    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        an_next = '1;
        if ((slot_cnt != '0) && lit) begin
            an_next[idx] = 1'b0;
        end
    end

`ifdef SEVENSEG_LZB_EN
    logic [NUM_DIGITS-1:0] lead_blank;

    // A digit blanks when it and every digit to its left are zero; digit 0 always shows.
    always_comb begin
        logic all_zero;
        all_zero   = 1'b1;
        lead_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero      = all_zero && (shadow_digits[4*i +: 4] == 4'h0);
            lead_blank[i] = all_zero;
        end
        lead_blank[0] = 1'b0;
    end

    always_comb begin
        seg_next = seg_decode(cur_nibble);
        if (lead_blank[idx]) begin
            seg_next = 7'h7F;
        end
    end
`else
    always_comb begin
        seg_next = seg_decode(cur_nibble);
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: the shadow buffer is a small register file, so it is cleared on reset to show zeros.
        if (!rst_n) begin
            slot_cnt      <= '0;
            idx           <= '0;
            pwm_cnt       <= '0;
            pending       <= 1'b0;
            shadow_digits <= '0;
            shadow_dps    <= '0;
            an            <= '1;
            seg           <= 7'h7F;
            dp            <= 1'b1;
            frame_done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge state.
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);

            if (slot_last) begin
                slot_cnt <= '0;
                idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end

            // A load arriving on the boundary clock itself joins the same copy.
            if (frame_last && (pending || load)) begin
                shadow_digits <= digits;
                shadow_dps    <= dps;
                pending       <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            an         <= an_next;
            seg        <= seg_next;
            dp         <= ~shadow_dps[idx];
            frame_done <= frame_last;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_n.sv
// Scoreboard bench for sevenseg_scan_n at NUM_DIGITS=4, SCAN_DIV=4, PWM_BITS=2.
// Define SEVENSEG_LZB_EN for both bench and design to select blanking expectations.
module tb_sevenseg_scan_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dps;
    logic        load;
    logic [1:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    sevenseg_scan_n #(
        .NUM_DIGITS(4),
        .SCAN_DIV  (4),
        .PWM_BITS  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits    (digits),
        .dps       (dps),
        .load      (load),
        .brightness(brightness),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t  sb_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    string tag         = "reset";

    // Reference state: position within the 16-clock frame, PWM phase, pending flag, shadow.
    int          cnt   = 0;
    int          pwm   = 0;
    bit          pend  = 1'b0;
    logic [15:0] m_digits = '0;
    logic [3:0]  m_dps    = '0;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[n];
    endfunction

    // Push the outputs expected right after the coming edge, then take that edge.
    task automatic step();
        exp_t e;
        int   di;
        int   slot;
        e.tag = tag;
        if (!rst_n) begin
            e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0;
            cnt = 0; pwm = 0; pend = 1'b0; m_digits = '0; m_dps = '0;
        end else begin
            di   = cnt / 4;
            slot = cnt % 4;
            e.an = 4'hF;
            if (slot != 0 && (brightness == 2'd3 || pwm < int'(brightness)))
                e.an[di] = 1'b0;
            e.seg = seg_of(m_digits[4*di +: 4]);
`ifdef SEVENSEG_LZB_EN
            if (di != 0 && (m_digits >> (4*di)) == 16'h0)
                e.seg = 7'h7F;
`endif
            e.dp = ~m_dps[di];
            e.fd = (cnt == 15);
            if (cnt == 15 && (pend || load)) begin
                m_digits = digits; m_dps = dps; pend = 1'b0;
            end else if (load) begin
                pend = 1'b1;
            end
            cnt = (cnt + 1) % 16;
            pwm = (pwm + 1) % 4;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_word(input logic [15:0] w, input logic [3:0] p);
        digits = w; dps = p; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // Monitor: compares one expected vector per clock, away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vectors++;
                if ({an, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                    miscompares++;
                    $display("FAIL %s @%0t: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                             e.tag, $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; digits = '0; dps = '0; load = 1'b0; brightness = 2'd3;

        tag = "reset";        run(3);
        rst_n = 1'b1;
        tag = "first_frame";  run(16);

        tag = "scan_order";
        load_word(16'h4321, 4'b0010);
        run(31);

        tag = "double_buffer";
        run(6);
        load_word(16'h1234, 4'b1000);
        run(9);
        digits = 16'hABCD; dps = 4'b0101;
        run(32);

        tag = "pwm_b0";       brightness = 2'd0; run(16);
        tag = "pwm_b2";       brightness = 2'd2; run(16);
        tag = "pwm_b1";       brightness = 2'd1; run(16);
        brightness = 2'd3;

        tag = "mid_reset";
        while (cnt != 10) step();
        rst_n = 1'b0;         step();
        rst_n = 1'b1;         run(20);

        tag = "lzb_0050";
        load_word(16'h0050, 4'b0001);
        run(31);
        tag = "lzb_0000";
        load_word(16'h0000, 4'b0000);
        run(31);

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
